// File: rtl/cd_multi_channel.sv
// Multi-channel programmable clock divider with per-channel enable and tick.
// Divisor writes are staged and applied only at a period boundary.
module cd_multi_channel #(
    parameter int NUM_CH    = 4,
    parameter int CNT_W     = 16,
    parameter int DIV_RESET = 2,
    localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic              cfg_wr,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_div,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] pending,
    output logic              cfg_err
);

    logic w_ch_ok;
    logic w_div_ok;
    logic w_wr_ok;
    logic r_err;

    assign w_ch_ok  = ({1'b0, cfg_ch} < (CH_W + 1)'(NUM_CH));
    assign w_div_ok = (cfg_div >= CNT_W'(2));
    assign w_wr_ok  = cfg_wr && w_ch_ok && w_div_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else begin
            r_err <= cfg_wr && !w_ch_ok;
            if (cfg_wr && !w_div_ok)
                r_err <= 1'b1;
        end
    end

    assign cfg_err = r_err;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [CNT_W-1:0] r_div;
        logic [CNT_W-1:0] r_cnt;
        logic [CNT_W-1:0] r_pdiv;
        logic             r_act;
        logic             r_pend;
        logic             r_clk;
        logic             r_tick;

        logic [CNT_W-1:0] w_div_n;
        logic [CNT_W-1:0] w_cnt_n;
        logic [CNT_W-1:0] w_pdiv_n;
        logic [CNT_W-1:0] w_h_n;
        logic             w_act_n;
        logic             w_pend_n;
        logic             w_wrap;
        logic             w_wr;

        assign w_wr   = w_wr_ok && (cfg_ch == CH_W'(g));
        assign w_wrap = (r_cnt == r_div - CNT_W'(1));

        always_comb begin
            w_div_n  = r_div;
            w_cnt_n  = r_cnt;
            w_pdiv_n = r_pdiv;
            w_act_n  = r_act;
            w_pend_n = r_pend;
            if (!ch_en[g]) begin
                w_act_n = 1'b0;
                w_cnt_n = '0;
                if (r_pend) begin
                    w_div_n  = r_pdiv;
                    w_pend_n = 1'b0;
                end
            end else if (!r_act) begin
                w_act_n = 1'b1;
                w_cnt_n = '0;
            end else if (w_wrap) begin
                w_cnt_n = '0;
                if (r_pend) begin
                    w_div_n  = r_pdiv;
                    w_pend_n = 1'b0;
                end
            end else begin
                w_cnt_n = r_cnt + CNT_W'(1);
            end
            // A write landing on a boundary stays staged for the next one.
            if (w_wr) begin
                w_pdiv_n = cfg_div;
                w_pend_n = 1'b1;
            end
        end

        // ceil(D/2) without needing a wider adder
        assign w_h_n = (w_div_n >> 1) + CNT_W'(w_div_n[0]);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_div  <= CNT_W'(DIV_RESET);
                r_cnt  <= '0;
                r_pdiv <= '0;
                r_act  <= 1'b0;
                r_pend <= 1'b0;
                r_clk  <= 1'b0;
                r_tick <= 1'b0;
            end else begin
                r_div  <= w_div_n;
                r_cnt  <= w_cnt_n;
                r_pdiv <= w_pdiv_n;
                r_act  <= w_act_n;
                r_pend <= w_pend_n;
                r_clk  <= w_act_n && (w_cnt_n < w_h_n);
                r_tick <= w_act_n && (w_cnt_n == w_div_n - CNT_W'(1));
            end
        end

        assign clk_out[g] = r_clk;
        assign tick[g]    = r_tick;
        assign pending[g] = r_pend;
    end

endmodule

// File: tb/tb_cd_multi_channel.sv
// Directed bench for cd_multi_channel: period shapes, staged divisor
// writes, rejected writes, enable drop and async reset.
module tb_cd_multi_channel;

    logic        clk;
    logic        rst_n;
    logic [3:0]  ch_en;
    logic        cfg_wr;
    logic [1:0]  cfg_ch;
    logic [15:0] cfg_div;
    logic [3:0]  clk_out;
    logic [3:0]  tick;
    logic [3:0]  pending;
    logic        cfg_err;

    int n_chk = 0;
    int n_err = 0;

    cd_multi_channel #(
        .NUM_CH    (4),
        .CNT_W     (16),
        .DIV_RESET (2)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ch_en   (ch_en),
        .cfg_wr  (cfg_wr),
        .cfg_ch  (cfg_ch),
        .cfg_div (cfg_div),
        .clk_out (clk_out),
        .tick    (tick),
        .pending (pending),
        .cfg_err (cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One char per cycle; pattern strings read left to right in time.
    task automatic run_ch(input int ch, input string cp, input string tp,
                          input string pp);
        for (int i = 0; i < cp.len(); i++) begin
            step();
            chk($sformatf("ch%0d_clk_c%0d", ch, i), 32'(clk_out[ch]),
                32'(cp.getc(i) == 8'h31));
            chk($sformatf("ch%0d_tick_c%0d", ch, i), 32'(tick[ch]),
                32'(tp.getc(i) == 8'h31));
            chk($sformatf("ch%0d_pend_c%0d", ch, i), 32'(pending[ch]),
                32'(pp.getc(i) == 8'h31));
        end
    endtask

    task automatic wr(input logic [1:0] ch, input logic [15:0] d);
        cfg_wr  = 1'b1;
        cfg_ch  = ch;
        cfg_div = d;
    endtask

    initial begin
        rst_n   = 1'b1;
        ch_en   = 4'b0000;
        cfg_wr  = 1'b0;
        cfg_ch  = 2'd0;
        cfg_div = 16'd0;
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_clk", 32'(clk_out), 32'h0);
        chk("rst_tick", 32'(tick), 32'h0);
        chk("rst_pend", 32'(pending), 32'h0);
        chk("rst_err", 32'(cfg_err), 32'h0);

        // ch0 at reset divisor 2
        rst_n = 1'b1;
        ch_en = 4'b0001;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("d2_clk", 32'(clk_out), (i % 2 == 0) ? 32'h1 : 32'h0);
            chk("d2_tick", 32'(tick), (i % 2 == 1) ? 32'h1 : 32'h0);
        end

        // ch1 div 4, staged while disabled
        wr(2'd1, 16'd4);
        step();
        cfg_wr = 1'b0;
        chk("w4_pend", 32'(pending), 32'h2);
        chk("w4_err", 32'(cfg_err), 32'h0);
        step();
        chk("w4_applied", 32'(pending[1]), 32'h0);
        ch_en = 4'b0011;
        run_ch(1, "11001100", "00010001", "00000000");

        // write div 5 on the wrap cycle: applied one period later
        wr(2'd1, 16'd5);
        step();
        cfg_wr = 1'b0;
        chk("w5_clk", 32'(clk_out[1]), 32'h1);
        chk("w5_tick", 32'(tick[1]), 32'h0);
        chk("w5_pend", 32'(pending[1]), 32'h1);
        run_ch(1, "100111001", "001000010", "111000000");

        // ch0: drop mid-period, stage div 4, then re-enable
        ch_en = 4'b0010;
        wr(2'd0, 16'd4);
        step();
        cfg_wr = 1'b0;
        chk("drop0_clk", 32'(clk_out[0]), 32'h0);
        chk("drop0_tick", 32'(tick[0]), 32'h0);
        chk("drop0_pend", 32'(pending[0]), 32'h1);
        step();
        chk("drop0_applied", 32'(pending[0]), 32'h0);
        ch_en = 4'b0011;
        run_ch(0, "11", "00", "00");

        // write div 6 at cnt=1: current period finishes at 4
        wr(2'd0, 16'd6);
        step();
        cfg_wr = 1'b0;
        chk("w6_clk", 32'(clk_out[0]), 32'h0);
        chk("w6_tick", 32'(tick[0]), 32'h0);
        chk("w6_pend", 32'(pending[0]), 32'h1);
        run_ch(0, "01110001", "10000010", "10000000");

        // rejected writes
        wr(2'd2, 16'd1);
        step();
        chk("err_div1", 32'(cfg_err), 32'h1);
        chk("err_div1_pend", 32'(pending), 32'h0);
        cfg_div = 16'd0;
        step();
        cfg_wr = 1'b0;
        chk("err_div0", 32'(cfg_err), 32'h1);
        step();
        chk("err_clear", 32'(cfg_err), 32'h0);
        chk("err_pend", 32'(pending), 32'h0);
        ch_en = 4'b0111;
        run_ch(2, "101", "010", "000");

        // ch1: drop, re-enable, then back-to-back writes 8 then 3
        ch_en = 4'b0101;
        step();
        chk("drop1_clk", 32'(clk_out[1]), 32'h0);
        chk("drop1_tick", 32'(tick[1]), 32'h0);
        ch_en = 4'b0111;
        step();
        chk("re1_clk", 32'(clk_out[1]), 32'h1);
        chk("re1_tick", 32'(tick[1]), 32'h0);
        wr(2'd1, 16'd8);
        step();
        chk("b8_clk", 32'(clk_out[1]), 32'h1);
        chk("b8_pend", 32'(pending[1]), 32'h1);
        cfg_div = 16'd3;
        step();
        cfg_wr = 1'b0;
        chk("b3_clk", 32'(clk_out[1]), 32'h1);
        chk("b3_pend", 32'(pending[1]), 32'h1);
        run_ch(1, "001101", "010010", "110000");

        // async reset mid-period with a write staged
        wr(2'd3, 16'd7);
        step();
        cfg_wr = 1'b0;
        chk("pre_rst_pend", 32'(pending[3]), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_clk", 32'(clk_out), 32'h0);
        chk("arst_tick", 32'(tick), 32'h0);
        chk("arst_pend", 32'(pending), 32'h0);
        chk("arst_err", 32'(cfg_err), 32'h0);
        ch_en = 4'b0001;
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("post_rst_clk", 32'(clk_out), (i % 2 == 0) ? 32'h1 : 32'h0);
            chk("post_rst_tick", 32'(tick), (i % 2 == 1) ? 32'h1 : 32'h0);
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/cd_multi_channel.md
Name: cd_multi_channel

Overview:
Parametrised multi-channel clock divider and successor to the fixed four-output divider (VGA/UART/LM/DB).
- Generates NUM_CH divided clocks from clk, each with a runtime-programmable divide ratio, per-channel enable and a one-cycle tick strobe.
- Divisor changes are glitch-free: a new value is applied only at a period boundary.
- Sits at the top level, feeding peripheral clock/enable domains.

Parameters:
NUM_CH, 4, number of output channels (>=1)
CNT_W, 16, divisor/counter width in bits
DIV_RESET, 2, divisor loaded into every channel at reset (2 <= DIV_RESET <= 2^CNT_W-1)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
ch_en  in  NUM_CH  per-channel run enable
cfg_wr  in  1  config write strobe, one cycle
cfg_ch  in  max(1,$clog2(NUM_CH))  target channel index
cfg_div  in  CNT_W  requested divide ratio
clk_out  out  NUM_CH  divided clock per channel, flop-driven
tick  out  NUM_CH  one-cycle pulse on last cycle of each period, flop-driven
pending  out  NUM_CH  1 = divisor write waiting for period boundary
cfg_err  out  1  one-cycle pulse for a rejected write

Behaviour:
- Reset (async assert, sync release) sets, per channel: div=DIV_RESET, cnt=0, active=0, pend_div=0, pending=0, clk_out=0, tick=0; also cfg_err=0.
- Per channel state: div (D), cnt, active, pend_div, pending.
- H = ceil(D/2). Invariant: whenever active=1, clk_out == (cnt < H) and tick == (cnt == D-1) in the same cycle. Both are registered: the decode is computed from next state. No combinational output path.
- Channel update, in priority order each edge:
  1. ch_en=0: next cycle active=0, cnt=0, clk_out=0, tick=0. If pending, apply pend_div to D immediately and clear pending.
  2. ch_en=1, active=0: active=1, cnt=0, clk_out=1, tick=0 (start of period).
  3. ch_en=1, active=1: cnt = (cnt==D-1) ? 0 : cnt+1.
     - On wrap (cnt==D-1), if pending: D=pend_div, pending=0.
     - The first period after the wrap uses the new D, including H.
- Config write, sampled on cfg_wr=1:
  - Valid when cfg_ch < NUM_CH and cfg_div >= 2. Sets pend_div[cfg_ch]=cfg_div and pending=1 at the next edge.
  - Otherwise cfg_err=1 for exactly one cycle; no state changes.
  - cfg_err=0 on all other cycles.
- Write to a channel that is already pending: the new value overwrites; last write wins.
- Write on the same cycle as a wrap: the wrap applies the previously pending value (if any). The new write becomes pending and applies at the next wrap.
- D values of 0 and 1 are never stored. Counter arithmetic is CNT_W-bit unsigned and never overflows, since cnt <= D-1.
- Channels are fully independent. Writes to one channel never disturb another channel's phase.
- Async reset mid-period forces all outputs low immediately. The next enabled cycle after release restarts at cnt=0.

Test Plan:
- Reset, ch_en=4'b0001, DIV_RESET=2 -> clk_out[0] toggles 1,0,1,0 from the cycle after enable; tick[0] high on every second cycle; other channels stay 0.
- Write ch1 div=4, enable ch1 -> clk_out[1] pattern 1,1,0,0 repeating; tick[1] on the 4th cycle. Write div=5 -> 1,1,1,0,0; tick on the 5th.
- ch0 running D=4; write div=6 when cnt=1 -> pending[0]=1; current period completes 4 cycles; next period is 6 cycles (1,1,1,0,0,0); pending drops on the wrap edge.
- Write cfg_div=1, and cfg_ch=NUM_CH (when NUM_CH is not a power of two) -> cfg_err one-cycle pulse each; no change to D or pending.
- Back-to-back writes div=8 then div=3 to one channel before the wrap -> 3 applied, 8 discarded. Write coinciding with the wrap cycle -> applied one period later.
- Drop ch_en mid-period -> clk_out/tick low next edge. Re-enable -> clk_out high next edge, cnt=0. Assert rst_n low mid-period -> all outputs 0 asynchronously; D back to DIV_RESET.
